// File: rtl/robbie_wheel_drive_pkg.sv
// Shared types and default parameters for the Robbie wheel-drive stage.
// The wheel state codes are also what the 7-segment display path decodes.
package robbie_wheel_drive_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ACCEL   = 2'd1,
    RUN     = 2'd2,
    DECEL   = 2'd3
  } wheel_state_e;

  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_DUTY_MAX = 255;
  localparam int unsigned DEF_RAMP_DIV = 50000;
  localparam int unsigned DEF_RAMP_W   = 16;

endpackage

// File: rtl/robbie_wheel_drive_if.sv
// Controller-side bundle of the wheel-drive stage.
// The master side drives the activate/stop requests; the slave side is the drive stage.
interface robbie_wheel_drive_if #(
  parameter int unsigned PWM_BITS = 8
);
  logic                lwa;
  logic                rwa;
  logic                estop;
  logic                l_pwm;
  logic                r_pwm;
  logic [1:0]          l_state;
  logic [1:0]          r_state;
  logic [PWM_BITS-1:0] l_duty;
  logic [PWM_BITS-1:0] r_duty;

  modport master (
    output lwa, rwa, estop,
    input  l_pwm, r_pwm, l_state, r_state, l_duty, r_duty
  );

  modport slave (
    input  lwa, rwa, estop,
    output l_pwm, r_pwm, l_state, r_state, l_duty, r_duty
  );
endinterface

// File: rtl/robbie_wheel_ramp.sv
// One wheel: soft-start/soft-stop duty ramp, motion FSM and PWM comparator.
// Emergency stop dominates; duty only moves on prescaler ticks.
module robbie_wheel_ramp
  import robbie_wheel_drive_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned DUTY_MAX = DEF_DUTY_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                act,
  input  logic                tick,
  input  logic                stop,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm,
  output wheel_state_e        state,
  output logic [PWM_BITS-1:0] duty
);

  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(DUTY_MAX);

  wheel_state_e        state_next;
  logic [PWM_BITS-1:0] duty_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOPPED;
      duty  <= '0;
      pwm   <= 1'b0;
    end else begin
      state <= state_next;
      duty  <= duty_next;
      pwm   <= (duty > pwm_cnt);
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
    if (stop) begin
      state_next = STOPPED;
      duty_next  = '0;
    end else begin
      if (tick) begin
        if (act && (duty < DMAX)) begin
          duty_next = duty + PWM_BITS'(1);
        end else if (!act && (duty != '0)) begin
          duty_next = duty - PWM_BITS'(1);
        end
      end
      // Direction follows act at once; RUN/STOPPED are only reached on a tick
      // that lands the duty on its limit.
      unique case (state)
        STOPPED: begin
          if (act) state_next = ACCEL;
        end
        ACCEL: begin
          if (!act) begin
            state_next = DECEL;
          end else if (tick && (duty_next == DMAX)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (!act) state_next = DECEL;
        end
        DECEL: begin
          if (act) begin
            state_next = ACCEL;
          end else if (tick && (duty_next == '0)) begin
            state_next = STOPPED;
          end
        end
        default: state_next = STOPPED;
      endcase
    end
  end

endmodule

// File: rtl/robbie_wheel_drive.sv
// Wheel-drive stage: input synchronizers, ramp prescaler and shared PWM counter
// feeding one ramp/PWM block per wheel.
module robbie_wheel_drive
  import robbie_wheel_drive_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned DUTY_MAX = DEF_DUTY_MAX,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV,
  parameter int unsigned RAMP_W   = DEF_RAMP_W
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  robbie_wheel_drive_if.slave  bus
);

  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  logic [1:0]          sync_l;
  logic [1:0]          sync_r;
  logic [1:0]          sync_e;
  logic                act_l;
  logic                act_r;
  logic                stop_s;
  logic [RAMP_W-1:0]   pre_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  wheel_state_e        l_st;
  wheel_state_e        r_st;

  // Controller inputs are switch-driven, so each gets a two-stage synchronizer.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync_l <= '0;
      sync_r <= '0;
      sync_e <= '0;
    end else begin
      sync_l <= {sync_l[0], bus.lwa};
      sync_r <= {sync_r[0], bus.rwa};
      sync_e <= {sync_e[0], bus.estop};
    end
  end

  assign act_l  = sync_l[1];
  assign act_r  = sync_r[1];
  assign stop_s = sync_e[1];

  // Prescaler and PWM counter keep running through an emergency stop.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + RAMP_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign tick = (pre_cnt == RAMP_LAST);

  robbie_wheel_ramp #(
    .PWM_BITS (PWM_BITS),
    .DUTY_MAX (DUTY_MAX)
  ) u_left (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .act     (act_l),
    .tick    (tick),
    .stop    (stop_s),
    .pwm_cnt (pwm_cnt),
    .pwm     (bus.l_pwm),
    .state   (l_st),
    .duty    (bus.l_duty)
  );

  robbie_wheel_ramp #(
    .PWM_BITS (PWM_BITS),
    .DUTY_MAX (DUTY_MAX)
  ) u_right (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .act     (act_r),
    .tick    (tick),
    .stop    (stop_s),
    .pwm_cnt (pwm_cnt),
    .pwm     (bus.r_pwm),
    .state   (r_st),
    .duty    (bus.r_duty)
  );

  assign bus.l_state = l_st;
  assign bus.r_state = r_st;

endmodule

// File: tb/tb_robbie_wheel_drive.sv
// Bench for robbie_wheel_drive: directed scenarios plus random activity, with every
// output compared each cycle against a behavioural wheel model.
module tb_robbie_wheel_drive;

  localparam int PWM_BITS = 4;
  localparam int DMAX     = 15;
  localparam int RDIV     = 4;
  localparam int PERIOD   = 16;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;
  int   n;
  int   hi_l;
  int   hi_r;
  int   d0;

  robbie_wheel_drive_if #(.PWM_BITS(PWM_BITS)) bus ();

  robbie_wheel_drive #(
    .PWM_BITS (PWM_BITS),
    .DUTY_MAX (DMAX),
    .RAMP_DIV (RDIV),
    .RAMP_W   (4)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Wheel model. "settled" = a tick has passed since act last changed;
  // "parked" = wheel at rest and not requested to move.
  typedef struct packed {
    int duty;
    int state;
    bit settled;
    bit parked;
    bit last_act;
    bit pwm;
  } wheel_m_t;

  function automatic wheel_m_t wheel_reset();
    wheel_m_t w;
    w.duty = 0; w.state = 0; w.settled = 1'b1; w.parked = 1'b1;
    w.last_act = 1'b0; w.pwm = 1'b0;
    return w;
  endfunction

  function automatic wheel_m_t wheel_step(wheel_m_t w, bit act, bit stop, bit tick, int cnt);
    wheel_m_t nw = w;
    bit changed = (act != w.last_act);
    nw.pwm      = (w.duty > cnt);
    nw.last_act = act;
    if (stop) begin
      nw.duty = 0; nw.state = 0; nw.settled = 1'b1; nw.parked = 1'b1;
      return nw;
    end
    if (tick) nw.duty = act ? ((w.duty + 1 > DMAX) ? DMAX : w.duty + 1)
                            : ((w.duty - 1 < 0) ? 0 : w.duty - 1);
    if (act) nw.parked = 1'b0;
    if (changed) nw.settled = 1'b0;
    else if (tick) nw.settled = 1'b1;
    if (!act && !changed && tick && nw.duty == 0) nw.parked = 1'b1;
    nw.state = nw.parked ? 0 : (act ? ((nw.settled && nw.duty == DMAX) ? 2 : 1) : 3);
    return nw;
  endfunction

  wheel_m_t ml, mr;
  bit [1:0] dl, dr, de;
  int       m_cyc;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ml    <= wheel_reset();
      mr    <= wheel_reset();
      dl    <= '0;
      dr    <= '0;
      de    <= '0;
      m_cyc <= 0;
    end else begin
      dl    <= {dl[0], bus.lwa};
      dr    <= {dr[0], bus.rwa};
      de    <= {de[0], bus.estop};
      ml    <= wheel_step(ml, dl[1], de[1], (m_cyc % RDIV) == RDIV - 1, m_cyc % PERIOD);
      mr    <= wheel_step(mr, dr[1], de[1], (m_cyc % RDIV) == RDIV - 1, m_cyc % PERIOD);
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    check("l_duty",  int'(bus.l_duty),  ml.duty);
    check("r_duty",  int'(bus.r_duty),  mr.duty);
    check("l_state", int'(bus.l_state), ml.state);
    check("r_state", int'(bus.r_state), mr.state);
    check("l_pwm",   int'(bus.l_pwm),   int'(ml.pwm));
    check("r_pwm",   int'(bus.r_pwm),   int'(mr.pwm));
  end

  initial begin
    n_tests = 0; n_fail = 0;
    resetn = 1'b0; bus.lwa = 1'b0; bus.rwa = 1'b0; bus.estop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_l_duty", int'(bus.l_duty), 0);
    check("rst_l_state", int'(bus.l_state), 0);
    check("rst_r_pwm", int'(bus.r_pwm), 0);
    resetn = 1'b1;

    // soft start
    bus.lwa = 1'b1;
    n = 0;
    while (bus.l_state != 2'd2 && n < 200) begin @(negedge clk); n++; end
    check("start_reached_run", int'(bus.l_state), 2);
    check("start_duty_max", int'(bus.l_duty), DMAX);
    check("start_latency_window", int'(n >= 56 && n <= 68), 1);

    // PWM shape at full duty, other wheel idle
    hi_l = 0; hi_r = 0;
    repeat (PERIOD) begin @(negedge clk); hi_l += int'(bus.l_pwm); hi_r += int'(bus.r_pwm); end
    check("pwm_high_at_15", hi_l, 15);
    check("pwm_high_at_0", hi_r, 0);

    // soft stop, reversal at duty 8, then full stop
    bus.lwa = 1'b0;
    repeat (3) @(negedge clk);
    check("stop_decel_state", int'(bus.l_state), 3);
    n = 0;
    while (bus.l_duty != 4'd8 && n < 100) begin @(negedge clk); n++; end
    check("stop_reached_8", int'(bus.l_duty), 8);
    bus.lwa = 1'b1;
    repeat (3) @(negedge clk);
    check("reverse_accel_state", int'(bus.l_state), 1);
    d0 = int'(bus.l_duty);
    repeat (8) @(negedge clk);
    check("reverse_duty_climbs", int'(int'(bus.l_duty) > d0), 1);
    bus.lwa = 1'b0;
    n = 0;
    while (bus.l_state != 2'd0 && n < 200) begin @(negedge clk); n++; end
    check("stop_parked_state", int'(bus.l_state), 0);
    repeat (20) @(negedge clk);
    check("stop_no_underflow", int'(bus.l_duty), 0);

    // emergency stop from full speed
    bus.lwa = 1'b1; bus.rwa = 1'b1;
    n = 0;
    while ((bus.l_state != 2'd2 || bus.r_state != 2'd2) && n < 200) begin @(negedge clk); n++; end
    check("estop_pre_run", int'(bus.r_state), 2);
    bus.estop = 1'b1;
    repeat (3) @(negedge clk);
    check("estop_l_duty", int'(bus.l_duty), 0);
    check("estop_r_state", int'(bus.r_state), 0);
    @(negedge clk);
    check("estop_pwm_low", int'(bus.l_pwm | bus.r_pwm), 0);
    repeat (6) @(negedge clk);
    check("estop_held", int'(bus.l_state), 0);
    bus.estop = 1'b0;
    repeat (4) @(negedge clk);
    check("estop_release_l", int'(bus.l_state), 1);
    check("estop_release_r", int'(bus.r_state), 1);

    // right input chatters while left ramps
    for (int i = 0; i < 40; i++) begin
      bus.rwa = ~bus.rwa;
      repeat (2) @(negedge clk);
    end
    check("glitch_left_run", int'(bus.l_state), 2);
    check("glitch_left_duty", int'(bus.l_duty), DMAX);
    check("glitch_right_bound", int'(bus.r_duty <= 4'(DMAX)), 1);

    // asynchronous reset in mid-ramp
    bus.lwa = 1'b0; bus.rwa = 1'b0;
    repeat (80) @(negedge clk);
    bus.lwa = 1'b1;
    n = 0;
    while (bus.l_duty != 4'd9 && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_duty9", int'(bus.l_duty), 9);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_duty", int'(bus.l_duty), 0);
    check("rst_async_state", int'(bus.l_state), 0);
    check("rst_async_pwm", int'(bus.l_pwm), 0);
    bus.lwa = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_after_duty", int'(bus.l_duty), 0);
    check("rst_after_state", int'(bus.l_state), 0);

    // random activity
    for (int i = 0; i < 80; i++) begin
      bus.lwa   = 1'($urandom_range(0, 1));
      bus.rwa   = 1'($urandom_range(0, 1));
      bus.estop = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    bus.estop = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/robbie_wheel_drive.md
Name: robbie_wheel_drive

Overview:
- Downstream stage of the Robbie controller: consumes left/right wheel-activate bits (lwa, rwa) and drives two wheel-motor PWM outputs.
- Adds soft-start/soft-stop duty ramping, so wheels accelerate and decelerate gradually instead of stepping on/off.
- Adds an emergency stop and per-wheel motion state for the 7-segment display path.
- Lives in the top level between the controller and the motor header / display.

Parameters:
PWM_BITS, 8, width of PWM counter and duty; PWM period = 2^PWM_BITS clocks
DUTY_MAX, 255, ramp ceiling (must be <= 2^PWM_BITS-1)
RAMP_DIV, 50000, clocks per duty step (ramp prescaler terminal count + 1), >= 1
RAMP_W, 16, width of ramp prescaler counter (2^RAMP_W >= RAMP_DIV)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
lwa  in  1  left-wheel activate from controller (may be asynchronous: switch-driven)
rwa  in  1  right-wheel activate from controller (asynchronous)
estop  in  1  emergency stop, active-high, asynchronous source
l_pwm  out  1  left motor PWM
r_pwm  out  1  right motor PWM
l_state  out  2  left wheel state code
r_state  out  2  right wheel state code
l_duty  out  PWM_BITS  left current duty
r_duty  out  PWM_BITS  right current duty

Behaviour:
- Reset (resetn=0, asynchronous):
  - All registers clear: synchronizers, prescaler, PWM counter and duties are 0.
  - Both states are STOPPED.
  - l_pwm = r_pwm = 0.
- Input synchronization:
  - lwa, rwa and estop each pass through a 2-FF synchronizer.
  - All logic below uses the synchronized values (act_l, act_r, stop_s).
  - Input-to-internal latency is 2 cycles.
- Ramp prescaler:
  - Free-running counter 0..RAMP_DIV-1, wraps to 0.
  - tick = 1 in the cycle where count == RAMP_DIV-1.
  - With RAMP_DIV=1, tick is asserted every cycle.
- PWM counter:
  - Free-running 0..2^PWM_BITS-1, wraps to 0.
  - Shared by both wheels.
- Per-wheel duty, updated only on tick:
  - act=1 and duty < DUTY_MAX: duty+1.
  - act=0 and duty > 0: duty-1.
  - Otherwise: hold.
  - Duty never exceeds DUTY_MAX and never underflows below 0.
- Per-wheel FSM, state codes STOPPED=0, ACCEL=1, RUN=2, DECEL=3:
  - STOPPED -> ACCEL when act=1. Duty starts rising at the next tick.
  - ACCEL -> RUN on the tick where duty becomes DUTY_MAX.
  - ACCEL -> DECEL when act=0.
  - RUN -> DECEL when act=0.
  - DECEL -> ACCEL when act=1.
  - DECEL -> STOPPED on the tick where duty becomes 0.
  - Edge case: act toggles during ACCEL/DECEL with no intervening tick. State follows act immediately; duty changes only on ticks.
- PWM output: pwm <= (duty > pwm_cnt), registered, one-cycle latency from duty/counter.
  - duty=0: constant 0.
  - duty=D: high D cycles of every 2^PWM_BITS.
- Emergency stop (stop_s=1), highest priority, overrides everything:
  - Both duties are forced to 0 and both states to STOPPED on the next edge.
  - PWM is low the cycle after that.
  - The condition holds for as long as stop_s=1; act inputs are ignored.
  - On release, normal ramping resumes from 0.
- Simultaneous events: estop beats tick beats act change. The prescaler and PWM counter keep running through estop.
- Outputs l_state, r_state, l_duty, r_duty are registered values, not decoded combinationally from inputs.

Decomposition:
- Shared package:
  - State encodings STOPPED/ACCEL/RUN/DECEL as 2-bit localparams.
  - Default PWM_BITS/DUTY_MAX/RAMP_DIV.
- Sub-module robbie_wheel_ramp, instantiated twice. It holds one wheel's act input, tick, estop, duty register, FSM and PWM comparator, and takes pwm_cnt in.
- Top level holds the synchronizers, prescaler and PWM counter.

Test Plan:
All scenarios run with PWM_BITS=4, DUTY_MAX=15, RAMP_DIV=4.
- Reset: assert resetn=0 mid-run with duty=9 -> duty=0, state=0, pwm=0 immediately (asynchronous); hold for 3 cycles after release with lwa=0 -> still all 0.
- Soft start: lwa=1 from reset -> l_state=1 within 3 cycles; l_duty reaches 15 after 15 ticks (60 cycles ±4), l_state=2; r_pwm stays 0 throughout.
- PWM shape: force duty to 5 (run until l_duty==5, then hold via RAMP_DIV large or check within one tick window) -> l_pwm high exactly 5 of each 16-cycle period; at duty 15 -> high 15 of 16.
- Soft stop and reversal: at RUN drop lwa -> state 3, duty decrements 1 per 4 cycles; raise lwa at duty=8 -> state 1, duty climbs from 8; drop again -> state=0 once duty hits 0, and duty does not underflow after further ticks.
- Emergency stop: both wheels RUN (duty 15), pulse estop=1 for 10 cycles -> within 3 cycles both duties=0, states=0, pwm=0 one cycle later; stays stopped with lwa=rwa=1 until release; then both ramp from 0 (state 1).
- Independence/glitch: rwa toggled 0/1 every 2 cycles while lwa steady 1 -> left ramps normally to 15; right duty stays bounded within [0,15] and state follows synchronized rwa with 2-cycle latency.
